wide_addsub_seq: RTL

Multi-precision add/subtract sequencer that reuses one N-bit carry-lookahead adder over WORDS cycles to produce an N*WORDS-bit result. It latches full-width operands through a valid/ready input handshake and feeds one word per cycle, LSW first, through the adder with a registered inter-word carry. It returns sum, carry-out, signed overflow and zero through a valid/ready output handshake. It sits between the datapath's operand registers and its writeback stage, wherever the required width exceeds a single adder.

---
 rtl/wide_addsub_pkg.sv | 23 ++
 rtl/wide_addsub_seq_cla.sv | 55 +++++
 rtl/wide_addsub_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/wide_addsub_pkg.sv
// Shared types and elaboration helpers for the multi-precision add/subtract sequencer.
// Holds the FSM state encoding, the word-index width helper and the adder width rules.
package wide_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ADDER_N_MULT = 4;
    localparam int ADDER_N_MIN  = 8;

    // At least one bit so a two-word configuration still has a usable index.
    function automatic int idx_width(input int words);
        return (words <= 2) ? 1 : $clog2(words);
    endfunction

    function automatic bit adder_n_ok(input int n);
        return ((n % ADDER_N_MULT) == 0) && (n >= ADDER_N_MIN);
    endfunction

endpackage

// File: rtl/wide_addsub_seq_cla.sv
// Parameterised N-bit carry-lookahead adder: 4-bit lookahead groups with
// group generate/propagate chained between groups.
module wide_addsub_seq_cla #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);

    localparam int NG = N / 4;

    logic [N-1:0]  w_g;
    logic [N-1:0]  w_p;
    logic [NG-1:0] w_gg;
    logic [NG-1:0] w_gp;
    logic [NG-1:0] w_gcin;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        localparam int B = 4 * k;
        logic [3:0] w_ci;
        logic       w_c0;

        assign w_c0    = w_gcin[k];
        assign w_ci[0] = w_c0;
        assign w_ci[1] = w_g[B] | (w_p[B] & w_c0);
        assign w_ci[2] = w_g[B+1] | (w_p[B+1] & w_g[B]) | (w_p[B+1] & w_p[B] & w_c0);
        assign w_ci[3] = w_g[B+2] | (w_p[B+2] & w_g[B+1]) | (w_p[B+2] & w_p[B+1] & w_g[B])
                       | (w_p[B+2] & w_p[B+1] & w_p[B] & w_c0);

        assign w_gg[k] = w_g[B+3] | (w_p[B+3] & w_g[B+2]) | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                       | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
        assign w_gp[k] = &w_p[B +: 4];

        assign o_sum[B +: 4] = w_p[B +: 4] ^ w_ci;
    end

    // Group carries walk through a local variable so no vector feeds back on itself.
    always_comb begin
        logic c;
        c      = i_cin;
        w_gcin = '0;
        for (int k = 0; k < NG; k++) begin
            w_gcin[k] = c;
            c         = w_gg[k] | (w_gp[k] & c);
        end
        o_cout = c;
    end

endmodule

// File: rtl/wide_addsub_seq.sv
// Multi-precision add/subtract: one shared N-bit CLA walks WORDS words LSW first,
// with a registered inter-word carry, between valid/ready handshakes.
module wide_addsub_seq
    import wide_addsub_pkg::*;
#(
    parameter int N     = 32,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] in_a,
    input  logic [N*WORDS-1:0] in_b,
    input  logic               in_sub,
    input  logic               in_cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] out_sum,
    output logic               out_cout,
    output logic               out_of,
    output logic               out_zero
);

    localparam int W  = N * WORDS;
    localparam int IW = idx_width(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    if (!adder_n_ok(N)) begin : g_bad_n
        $error("wide_addsub_seq: N must be a multiple of 4 and at least 8");
    end
    if (WORDS < 2) begin : g_bad_words
        $error("wide_addsub_seq: WORDS must be at least 2");
    end

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic [IW-1:0]   r_idx;
    logic            r_carry;
    logic            r_cout;
    logic            r_of;
    logic            r_zero;

    logic [N-1:0]    w_a_word;
    logic [N-1:0]    w_b_word;
    logic [N-1:0]    w_sum_word;
    logic            w_word_cout;
    logic [W-1:0]    w_res_nxt;
    logic            w_accept;
    logic            w_last;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_idx == LAST_IDX);
    assign w_a_word = r_a[r_idx*N +: N];
    assign w_b_word = r_b[r_idx*N +: N];

    wide_addsub_seq_cla #(.N(N)) u_cla (
        .i_a    (w_a_word),
        .i_b    (w_b_word),
        .i_cin  (r_carry),
        .o_sum  (w_sum_word),
        .o_cout (w_word_cout)
    );

    // Result as it will look after this cycle's word lands; used for the zero flag.
    always_comb begin
        w_res_nxt                 = r_sum;
        w_res_nxt[r_idx*N +: N]   = w_sum_word;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_of    <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= in_a;
                        r_b     <= in_sub ? ~in_b : in_b;
                        r_carry <= in_sub | in_cin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum[r_idx*N +: N] <= w_sum_word;
                    r_carry             <= w_word_cout;
                    if (w_last) begin
                        r_idx  <= '0;
                        r_cout <= w_word_cout;
                        r_of   <= (w_a_word[N-1] == w_b_word[N-1]) &&
                                  (w_sum_word[N-1] != w_a_word[N-1]);
                        r_zero <= ~|w_res_nxt;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_of    = r_of;
    assign out_zero  = r_zero;

endmodule
